// File: rtl/sequenciador_pkg.sv
// Shared note codes, segment patterns and playback states
// for the note sequencer.
package sequenciador_pkg;

    localparam logic [2:0] NOTA_C     = 3'd0;
    localparam logic [2:0] NOTA_D     = 3'd1;
    localparam logic [2:0] NOTA_E     = 3'd2;
    localparam logic [2:0] NOTA_F     = 3'd3;
    localparam logic [2:0] NOTA_G     = 3'd4;
    localparam logic [2:0] NOTA_A     = 3'd5;
    localparam logic [2:0] NOTA_B     = 3'd6;
    localparam logic [2:0] NOTA_PAUSA = 3'd7;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_G     = 7'b0111101;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_PAUSA = 7'b1000000;

    typedef enum logic {IDLE, PLAY} estado_t;

endpackage

// File: rtl/nota_para_7seg.sv
// Combinational note code to 7-segment pattern.
module nota_para_7seg
    import sequenciador_pkg::*;
(
    input  logic [2:0] nota,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_PAUSA;
        case (nota)
            NOTA_C:  seg = SEG_C;
            NOTA_D:  seg = SEG_D;
            NOTA_E:  seg = SEG_E;
            NOTA_F:  seg = SEG_F;
            NOTA_G:  seg = SEG_G;
            NOTA_A:  seg = SEG_A;
            NOTA_B:  seg = SEG_B;
            default: seg = SEG_PAUSA;
        endcase
    end

endmodule

// File: rtl/sequenciador_notas.sv
// Programmable note sequencer: step memory, tick-driven playback
// and registered 7-segment readout of the current note.
module sequenciador_notas
    import sequenciador_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DUR_W = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic             WR_TOM,
    input  logic [2:0]       WR_NOTA,
    input  logic [DUR_W-1:0] WR_DUR,
    input  logic [LW-1:0]    LEN,
    input  logic             LOOP,
    input  logic             START,
    input  logic             STOP,
    input  logic             PAUSA,
    input  logic             TICK,
    output logic [6:0]       SAIDA,
    output logic             SUST,
    output logic [AW-1:0]    PASSO,
    output logic             TOCANDO,
    output logic             FIM
);

    logic             mem_tom_q  [DEPTH];
    logic [2:0]       mem_nota_q [DEPTH];
    logic [DUR_W-1:0] mem_dur_q  [DEPTH];

    estado_t          estado_q, estado_d;
    logic [AW-1:0]    passo_q, passo_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [LW-1:0]    len_q, len_d;
    logic             loop_q, loop_d;
    logic [2:0]       nota_q, nota_d;
    logic             tom_q, tom_d;
    logic             fim_q, fim_d;
    logic [6:0]       saida_q, saida_d;

    logic [LW-1:0]    len_eff;
    logic             ultimo;
    logic             carrega;
    logic [AW-1:0]    end_carga;

    nota_para_7seg u_dec (
        .nota (nota_d),
        .seg  (saida_d)
    );

    assign len_eff = (LEN > LW'(DEPTH)) ? LW'(DEPTH) : LEN;
    assign ultimo  = (LW'(passo_q) + LW'(1)) == len_q;

    always_comb begin
        estado_d  = estado_q;
        passo_d   = passo_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        loop_d    = loop_q;
        nota_d    = nota_q;
        tom_d     = tom_q;
        fim_d     = 1'b0;
        carrega   = 1'b0;
        end_carga = AW'(0);

        if (STOP) begin
            estado_d = IDLE;
            nota_d   = NOTA_PAUSA;
            tom_d    = 1'b0;
        end else if (START && len_eff != LW'(0)) begin
            estado_d = PLAY;
            len_d    = len_eff;
            loop_d   = LOOP;
            carrega  = 1'b1;
        end else if (estado_q == PLAY && TICK && !PAUSA) begin
            if (cnt_q > DUR_W'(1)) begin
                cnt_d = cnt_q - DUR_W'(1);
            end else if (!ultimo) begin
                carrega   = 1'b1;
                end_carga = passo_q + AW'(1);
            end else if (loop_q) begin
                carrega = 1'b1;
            end else begin
                estado_d = IDLE;
                fim_d    = 1'b1;
                nota_d   = NOTA_PAUSA;
                tom_d    = 1'b0;
            end
        end

        // Memory is read from the registered copy, so a same-edge write
        // to the loaded address is seen only on the following load.
        if (carrega) begin
            passo_d = end_carga;
            nota_d  = mem_nota_q[end_carga];
            tom_d   = mem_tom_q[end_carga] && (nota_d != NOTA_PAUSA);
            cnt_d   = (mem_dur_q[end_carga] == '0) ? DUR_W'(1)
                                                  : mem_dur_q[end_carga];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_tom_q[i]  <= 1'b0;
                mem_nota_q[i] <= NOTA_PAUSA;
                mem_dur_q[i]  <= DUR_W'(1);
            end
        end else if (WR_EN) begin
            mem_tom_q[WR_ADDR]  <= WR_TOM;
            mem_nota_q[WR_ADDR] <= WR_NOTA;
            mem_dur_q[WR_ADDR]  <= WR_DUR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= IDLE;
            passo_q  <= '0;
            cnt_q    <= DUR_W'(1);
            len_q    <= '0;
            loop_q   <= 1'b0;
            nota_q   <= NOTA_PAUSA;
            tom_q    <= 1'b0;
            fim_q    <= 1'b0;
            saida_q  <= SEG_PAUSA;
        end else begin
            estado_q <= estado_d;
            passo_q  <= passo_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            loop_q   <= loop_d;
            nota_q   <= nota_d;
            tom_q    <= tom_d;
            fim_q    <= fim_d;
            saida_q  <= saida_d;
        end
    end

    assign SAIDA   = saida_q;
    assign SUST    = tom_q;
    assign PASSO   = passo_q;
    assign TOCANDO = (estado_q == PLAY);
    assign FIM     = fim_q;

endmodule

// File: tb/tb_sequenciador_notas.sv
// Directed bench for the note sequencer with hand-computed
// expected segment, step and status values.
module tb_sequenciador_notas;

    localparam logic [6:0] S_C = 7'b0111001;
    localparam logic [6:0] S_E = 7'b1111001;
    localparam logic [6:0] S_F = 7'b1110001;
    localparam logic [6:0] S_A = 7'b1110111;
    localparam logic [6:0] S_R = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst;
    logic       WR_EN;
    logic [2:0] WR_ADDR;
    logic       WR_TOM;
    logic [2:0] WR_NOTA;
    logic [7:0] WR_DUR;
    logic [3:0] LEN;
    logic       LOOP, START, STOP, PAUSA, TICK;
    logic [6:0] SAIDA;
    logic       SUST;
    logic [2:0] PASSO;
    logic       TOCANDO, FIM;

    int total = 0;
    int bad   = 0;

    sequenciador_notas dut (
        .clk     (clk),
        .rst     (rst),
        .WR_EN   (WR_EN),
        .WR_ADDR (WR_ADDR),
        .WR_TOM  (WR_TOM),
        .WR_NOTA (WR_NOTA),
        .WR_DUR  (WR_DUR),
        .LEN     (LEN),
        .LOOP    (LOOP),
        .START   (START),
        .STOP    (STOP),
        .PAUSA   (PAUSA),
        .TICK    (TICK),
        .SAIDA   (SAIDA),
        .SUST    (SUST),
        .PASSO   (PASSO),
        .TOCANDO (TOCANDO),
        .FIM     (FIM)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic t,
                      input logic [2:0] n, input logic [7:0] d);
        WR_ADDR = a;
        WR_TOM  = t;
        WR_NOTA = n;
        WR_DUR  = d;
        WR_EN   = 1'b1;
        step();
        WR_EN   = 1'b0;
    endtask

    task automatic go(input logic [3:0] l, input logic lp);
        LEN   = l;
        LOOP  = lp;
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    int exp_loop [9] = '{0, 0, 1, 2, 2, 2, 0, 0, 1};
    int exp_long [11] = '{0, 0, 1, 2, 2, 2, 3, 4, 5, 6, 7};

    initial begin
        rst = 1'b1;
        WR_EN = 0; WR_ADDR = 0; WR_TOM = 0; WR_NOTA = 0; WR_DUR = 0;
        LEN = 0; LOOP = 0; START = 0; STOP = 0; PAUSA = 0; TICK = 0;
        step();
        step();
        rst = 1'b0;
        repeat (5) step();
        chk("rst_saida", SAIDA, S_R);
        chk("rst_sust", SUST, 0);
        chk("rst_toc", TOCANDO, 0);
        chk("rst_fim", FIM, 0);
        chk("rst_passo", PASSO, 0);

        wr(0, 0, 0, 2);
        wr(1, 1, 2, 0);
        wr(2, 0, 5, 3);

        TICK = 1'b1;
        go(3, 0);
        chk("p0_saida", SAIDA, S_C);
        chk("p0_toc", TOCANDO, 1);
        chk("p0_passo", PASSO, 0);
        step();
        chk("p1_saida", SAIDA, S_C);
        step();
        chk("p2_saida", SAIDA, S_E);
        chk("p2_sust", SUST, 1);
        chk("p2_passo", PASSO, 1);
        step();
        chk("p3_saida", SAIDA, S_A);
        chk("p3_sust", SUST, 0);
        step();
        chk("p4_saida", SAIDA, S_A);
        chk("p4_fim", FIM, 0);
        step();
        chk("p5_saida", SAIDA, S_A);
        step();
        chk("end_fim", FIM, 1);
        chk("end_toc", TOCANDO, 0);
        chk("end_saida", SAIDA, S_R);
        step();
        chk("end_fim_low", FIM, 0);

        go(3, 1);
        chk("loop_passo_0", PASSO, exp_loop[0]);
        for (int i = 1; i < 9; i++) begin
            step();
            chk($sformatf("loop_passo_%0d", i), PASSO, exp_loop[i]);
            chk($sformatf("loop_fim_%0d", i), FIM, 0);
        end
        STOP  = 1'b1;
        START = 1'b1;
        step();
        STOP  = 1'b0;
        START = 1'b0;
        chk("stopstart_toc", TOCANDO, 0);
        chk("stopstart_fim", FIM, 0);
        chk("stopstart_saida", SAIDA, S_R);

        go(3, 0);
        repeat (3) step();
        chk("pz_saida", SAIDA, S_A);
        step();
        PAUSA = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("pz_hold_%0d", i), PASSO, 2);
            chk($sformatf("pz_toc_%0d", i), TOCANDO, 1);
        end
        PAUSA = 1'b0;
        step();
        chk("pz_last", SAIDA, S_A);
        chk("pz_last_toc", TOCANDO, 1);
        step();
        chk("pz_fim", FIM, 1);
        chk("pz_toc_off", TOCANDO, 0);

        go(0, 0);
        chk("len0_toc", TOCANDO, 0);
        chk("len0_fim", FIM, 0);
        step();
        chk("len0_fim2", FIM, 0);

        wr(3, 0, 3, 1);
        wr(4, 1, 4, 1);
        wr(5, 0, 6, 1);
        wr(6, 0, 1, 1);
        wr(7, 0, 7, 1);
        go(15, 0);
        chk("long_passo_0", PASSO, 0);
        for (int m = 1; m < 11; m++) begin
            step();
            chk($sformatf("long_passo_%0d", m), PASSO, exp_long[m]);
            chk($sformatf("long_toc_%0d", m), TOCANDO, 1);
            if (m == 6) chk("long_f", SAIDA, S_F);
        end
        step();
        chk("long_fim", FIM, 1);
        chk("long_toc_off", TOCANDO, 0);

        go(3, 1);
        step();
        step();
        chk("rm_passo", PASSO, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rm_saida", SAIDA, S_R);
        chk("rm_passo0", PASSO, 0);
        chk("rm_toc", TOCANDO, 0);
        chk("rm_fim", FIM, 0);
        chk("rm_sust", SUST, 0);

        go(8, 0);
        for (int m = 0; m < 8; m++) begin
            if (m > 0) step();
            chk($sformatf("clr_passo_%0d", m), PASSO, m);
            chk($sformatf("clr_saida_%0d", m), SAIDA, S_R);
            chk($sformatf("clr_sust_%0d", m), SUST, 0);
        end
        step();
        chk("clr_fim", FIM, 1);
        TICK = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
